block_data_memory: RTL

- Responder end of the cache-to-memory block interface.
- Single-ported, line-granular backing store that accepts one read or write request at a time and completes it after a fixed latency.
- A `mem_ready`/`is_input_valid` handshake governs acceptance.
- Sits below the data cache, which issues line fills and dirty-line write-backs to it.

---
 rtl/block_data_memory_pkg.sv | 32 +++
 rtl/block_data_memory_latency_counter.sv | 57 +++++
 rtl/block_data_memory.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/block_data_memory_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : block_data_memory_pkg
//  Description : Shared definitions for the line-granular data memory:
//                FSM state encoding, default line width, the CLOG2 helper
//                macro and a line-width helper function.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

package block_data_memory_pkg;

  // Two-state responder FSM
  localparam logic [0:0] DMEM_IDLE = 1'b0;
  localparam logic [0:0] DMEM_BUSY = 1'b1;

  // Default line geometry (bytes per line and resulting bus width)
  localparam int DMEM_BLOCK_SIZE = 16;
  localparam int DMEM_LINE_W     = DMEM_BLOCK_SIZE * 8;

  // Bus width in bits for a line of block_size bytes
  function automatic int dmem_line_width(input int block_size);
    return block_size * 8;
  endfunction

endpackage : block_data_memory_pkg

`default_nettype wire

// File: rtl/block_data_memory_latency_counter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_latency_counter
//  Description : Loadable down-counter that times the fixed access latency.
//                Counts down to zero and stops; 'done' is high while the
//                count equals 1, i.e. in the cycle whose closing edge is the
//                completion edge of the pending access.
//  Ports       : clk    - clock
//                reset  - synchronous active-high reset (count -> 0)
//                load   - load 'value' on the next rising edge
//                value  - reload value (the latency)
//                done   - count == 1
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

module dmem_latency_counter
  import block_data_memory_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             done
);

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (count_q != '0) begin
      // Saturate at zero so an idle counter never reports done
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == WIDTH'(1));

endmodule : dmem_latency_counter

`default_nettype wire

// File: rtl/block_data_memory.sv
`default_nettype none
// ============================================================================
//  Module      : block_data_memory
//  Description : Responder end of the cache-to-memory block interface.
//                Single-ported line store; accepts one read or write when
//                mem_ready is high and completes it DELAY cycles later.
//                The array starts zeroed; INIT_FILE is kept for interface
//                compatibility and is not used.
//  Ports       : clk             - clock, rising edge
//                reset           - synchronous active-high reset
//                is_input_valid  - request present
//                addr[31:0]      - line address (already line-aligned index)
//                mem_read        - request is a line read
//                mem_write       - request is a line write
//                din             - write line data
//                is_output_valid - one-cycle pulse, dout carries read data
//                dout            - read line data, held until next read
//                mem_ready       - a new request can be accepted
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

module block_data_memory
  import block_data_memory_pkg::*;
#(
  parameter int    BLOCK_SIZE = 16,
  parameter int    NUM_LINES  = 16384,
  parameter int    DELAY      = 50,
  parameter string INIT_FILE  = "dmem.hex"
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    is_input_valid,
  input  logic [31:0]             addr,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [BLOCK_SIZE*8-1:0] din,
  output logic                    is_output_valid,
  output logic [BLOCK_SIZE*8-1:0] dout,
  output logic                    mem_ready
);

  localparam int LINE_W = dmem_line_width(BLOCK_SIZE);
  localparam int IDX_W  = `CLOG2(NUM_LINES);
  localparam int CNT_W  = `CLOG2(DELAY + 1);

  // ---------------------------------------------------------------------------
  // Backing store. Never cleared by reset.
  // ---------------------------------------------------------------------------
  logic [LINE_W-1:0] mem_array [NUM_LINES];

  localparam string unused_init_file = INIT_FILE;
  initial begin
    for (int i = 0; i < NUM_LINES; i++) begin
      mem_array[i] = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Request state
  // ---------------------------------------------------------------------------
  logic [0:0]        state_d,    state_q;
  logic [IDX_W-1:0]  idx_d,      idx_q;
  logic [LINE_W-1:0] wdata_d,    wdata_q;
  logic              is_write_d, is_write_q;
  logic [LINE_W-1:0] dout_d,     dout_q;
  logic              valid_d,    valid_q;

  logic cnt_load;
  logic cnt_done;
  logic mem_we;
  logic accept;

  // Upper address bits are deliberately ignored: addresses wrap modulo NUM_LINES
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:IDX_W];

  // Exactly one of read/write must be set; anything else is dropped
  assign accept = is_input_valid && (mem_read ^ mem_write);

  dmem_latency_counter #(
    .WIDTH (CNT_W)
  ) u_latency (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load),
    .value (CNT_W'(DELAY)),
    .done  (cnt_done)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    is_write_d = is_write_q;
    dout_d     = dout_q;
    valid_d    = 1'b0;
    cnt_load   = 1'b0;
    mem_we     = 1'b0;

    case (state_q)
      DMEM_IDLE: begin
        if (accept) begin
          idx_d      = addr[IDX_W-1:0];
          wdata_d    = din;
          is_write_d = mem_write;
          cnt_load   = 1'b1;
          state_d    = DMEM_BUSY;
        end
      end
      DMEM_BUSY: begin
        // Inputs are ignored here; only the latched request matters
        if (cnt_done) begin
          if (is_write_q) begin
            mem_we = 1'b1;
          end else begin
            dout_d  = mem_array[idx_q];
            valid_d = 1'b1;
          end
          state_d = DMEM_IDLE;
        end
      end
      default: begin
        state_d = DMEM_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= DMEM_IDLE;
      idx_q      <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      dout_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      is_write_q <= is_write_d;
      dout_q     <= dout_d;
      valid_q    <= valid_d;
    end
  end

  // Array write port; a reset on the completion edge abandons the write.
  // Kept as a plain always so the zero-fill initial block may share the array.
  always @(posedge clk) begin
    if (mem_we && !reset) begin
      mem_array[idx_q] <= wdata_q;
    end
  end

  assign mem_ready       = (state_q == DMEM_IDLE);
  assign is_output_valid = valid_q;
  assign dout            = dout_q;

endmodule : block_data_memory

`default_nettype wire
